// File: rtl/vector_processor_pkg.sv
// Shared types and helpers for the vector execute stage reduction path.
// Optional min/max reduction support is compiled in with VRED_MINMAX_EN.
package vector_processor_pkg;

  localparam int CHUNK_W = 32;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } red_state_e;

`ifdef VRED_MINMAX_EN
  typedef enum logic [1:0] {
    RED_SUM  = 2'b00,
    RED_MAX  = 2'b01,
    RED_MIN  = 2'b10,
    RED_MAXU = 2'b11
  } red_op_e;
`endif

  // Encoding 11 is reserved and behaves as 32-bit elements.
  function automatic sew_e decode_sew(input logic [1:0] raw);
    case (raw)
      2'b00:   return SEW8;
      2'b01:   return SEW16;
      default: return SEW32;
    endcase
  endfunction

  function automatic logic [CHUNK_W-1:0] sew_mask(input logic [CHUNK_W-1:0] x,
                                                  input sew_e sew);
    case (sew)
      SEW8:    return {24'b0, x[7:0]};
      SEW16:   return {16'b0, x[15:0]};
      default: return x;
    endcase
  endfunction

`ifdef VRED_MINMAX_EN
  // One extra bit lets signed and unsigned compares share a single comparator.
  function automatic logic signed [CHUNK_W:0] sew_ext(input logic [CHUNK_W-1:0] x,
                                                      input sew_e sew,
                                                      input logic sgn);
    case (sew)
      SEW8:    return {{25{sgn & x[7]}}, x[7:0]};
      SEW16:   return {{17{sgn & x[15]}}, x[15:0]};
      default: return {sgn & x[31], x};
    endcase
  endfunction

  function automatic logic [CHUNK_W-1:0] red_combine(input logic [CHUNK_W-1:0] a,
                                                     input logic [CHUNK_W-1:0] b,
                                                     input sew_e sew,
                                                     input red_op_e op);
    logic signed [CHUNK_W:0] ea;
    logic signed [CHUNK_W:0] eb;
    ea = sew_ext(a, sew, op != RED_MAXU);
    eb = sew_ext(b, sew, op != RED_MAXU);
    case (op)
      RED_MAX, RED_MAXU: return sew_mask((ea >= eb) ? a : b, sew);
      RED_MIN:           return sew_mask((ea <= eb) ? a : b, sew);
      default:           return sew_mask(a + b, sew);
    endcase
  endfunction
`endif

endpackage

// File: rtl/vred_chunk_fold.sv
// Combinational fold of one 32-bit chunk into a single SEW-wide partial value.
// With VRED_MINMAX_EN the fold also supports signed/unsigned max and signed min.
module vred_chunk_fold
  import vector_processor_pkg::*;
(
  input  logic [CHUNK_W-1:0] chunk,
  input  sew_e               sew,
  input  logic [3:0]         active,
`ifdef VRED_MINMAX_EN
  input  red_op_e            op,
`endif
  output logic [CHUNK_W-1:0] partial
);

  logic [7:0]         byte_lane [4];
  logic [CHUNK_W-1:0] elem      [4];
  logic [3:0]         lane_on;
  logic [CHUNK_W-1:0] fold_acc;
`ifdef VRED_MINMAX_EN
  logic               fold_have;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = chunk[gi*8 +: 8];
    end
  endgenerate

  // Lanes beyond the element count of the current SEW are forced off.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elem[i] = '0;
    end
    lane_on = '0;
    case (sew)
      SEW8: begin
        for (int i = 0; i < 4; i++) begin
          elem[i] = {24'b0, byte_lane[i]};
        end
        lane_on = active;
      end
      SEW16: begin
        elem[0] = {16'b0, byte_lane[1], byte_lane[0]};
        elem[1] = {16'b0, byte_lane[3], byte_lane[2]};
        lane_on = {2'b00, active[1:0]};
      end
      default: begin
        elem[0] = chunk;
        lane_on = {3'b000, active[0]};
      end
    endcase
  end

  // Inactive lanes are skipped entirely, so min/max never sees a zero filler.
  always_comb begin
    fold_acc = '0;
`ifdef VRED_MINMAX_EN
    fold_have = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (lane_on[i]) begin
`ifdef VRED_MINMAX_EN
        fold_acc  = fold_have ? red_combine(fold_acc, elem[i], sew, op) : elem[i];
        fold_have = 1'b1;
`else
        fold_acc  = fold_acc + elem[i];
`endif
      end
    end
    partial = sew_mask(fold_acc, sew);
  end

endmodule

// File: rtl/vector_reduction_unit.sv
// Multi-cycle vector reduction: folds vs2 one 32-bit chunk per cycle into a seeded scalar.
// Defining VRED_MINMAX_EN adds the op port and max/min reductions.
`ifndef VLEN
`define VLEN 512
`endif

module vector_reduction_unit
  import vector_processor_pkg::*;
#(
  parameter int VLEN    = `VLEN,
  parameter int CHUNK_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 sew,
  input  logic [$clog2(VLEN/8):0]    vl,
  input  logic [VLEN-1:0]            vs2,
  input  logic [31:0]                vs1_scalar,
`ifdef VRED_MINMAX_EN
  input  logic [1:0]                 op,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                result,
  output logic                       busy
);

  localparam int NCHUNK = VLEN / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int VL_W   = $clog2(VLEN/8) + 1;

  red_state_e         state_reg, state_next;
  sew_e               sew_reg, sew_next;
  logic [VL_W-1:0]    vl_reg, vl_next;
  logic [VLEN-1:0]    vs2_reg, vs2_next;
  logic [31:0]        acc_reg, acc_next;
  logic [CNT_W-1:0]   chunk_reg, chunk_next;
`ifdef VRED_MINMAX_EN
  red_op_e            op_reg, op_next;
`endif

  logic [31:0]        base_idx;
  logic [31:0]        epc;
  logic [31:0]        vl_ext;
  logic [3:0]         lane_active;
  logic               last_chunk;
  logic [31:0]        partial;

  assign vl_ext = 32'(vl_reg);

  always_comb begin
    case (sew_reg)
      SEW8: begin
        base_idx = 32'(chunk_reg) << 2;
        epc      = 32'd4;
      end
      SEW16: begin
        base_idx = 32'(chunk_reg) << 1;
        epc      = 32'd2;
      end
      default: begin
        base_idx = 32'(chunk_reg);
        epc      = 32'd1;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_active[gi] = (base_idx + 32'(gi)) < vl_ext;
    end
  endgenerate

  // The chunk cap also covers vl beyond VLEN/SEW: every element is then active.
  assign last_chunk = ((base_idx + epc) >= vl_ext) ||
                      (chunk_reg == CNT_W'(NCHUNK - 1));

  // vs2 is shifted down each ACCUM cycle so the current chunk is always the low word.
  vred_chunk_fold u_fold (
    .chunk   (vs2_reg[CHUNK_W-1:0]),
    .sew     (sew_reg),
    .active  (lane_active),
`ifdef VRED_MINMAX_EN
    .op      (op_reg),
`endif
    .partial (partial)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sew_reg   <= SEW8;
      vl_reg    <= '0;
      vs2_reg   <= '0;
      acc_reg   <= '0;
      chunk_reg <= '0;
`ifdef VRED_MINMAX_EN
      op_reg    <= RED_SUM;
`endif
    end else begin
      state_reg <= state_next;
      sew_reg   <= sew_next;
      vl_reg    <= vl_next;
      vs2_reg   <= vs2_next;
      acc_reg   <= acc_next;
      chunk_reg <= chunk_next;
`ifdef VRED_MINMAX_EN
      op_reg    <= op_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    sew_next   = sew_reg;
    vl_next    = vl_reg;
    vs2_next   = vs2_reg;
    acc_next   = acc_reg;
    chunk_next = chunk_reg;
`ifdef VRED_MINMAX_EN
    op_next    = op_reg;
`endif
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    result     = '0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          sew_next   = decode_sew(sew);
          vl_next    = vl;
          vs2_next   = vs2;
          acc_next   = sew_mask(vs1_scalar, decode_sew(sew));
          chunk_next = '0;
`ifdef VRED_MINMAX_EN
          op_next    = red_op_e'(op);
`endif
          state_next = (vl != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
`ifdef VRED_MINMAX_EN
        acc_next = red_combine(acc_reg, partial, sew_reg, op_reg);
`else
        acc_next = sew_mask(acc_reg + partial, sew_reg);
`endif
        vs2_next   = vs2_reg >> CHUNK_W;
        chunk_next = chunk_reg + CNT_W'(1);
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        result    = acc_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
